// File: rtl/matrix_inverse_seq.sv
// Sequential Gauss-Jordan inverse of an NxN signed Q(W-FRAC).FRAC matrix. One element is updated per cycle.
// Latency: N*N*(2N+1) cycles from the last input handshake to the first out_valid, unless a zero pivot occurs.
// Backpressure: in_ready is high only in LOAD. In OUT the current element is held stable while out_ready is low.
//
// Ports:
//   clk, reset                        - rising-edge clock; synchronous active-high reset
//   in_valid/in_ready/in_data         - matrix A elements, row-major
//   out_valid/out_ready/out_data      - inverse elements, row-major
//   out_last                          - marks element N*N-1 of the output stream
//   busy                              - high in every state except LOAD
//   done                              - one-cycle pulse when a job ends
//   singular                          - sticky error flag for the job that just ended
// Optional build macro MATINV_PIVOT_SWAP_EN: on a zero pivot, search the rows below
// for a nonzero column-k entry and swap it into row k. Without the macro, the job is flagged singular.
module matrix_inverse_seq #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         singular
);

    localparam int RB = $clog2(N);
    localparam int CB = $clog2(2 * N);

    localparam logic [RB-1:0]          LAST_ROW  = RB'(N - 1);
    localparam logic [CB-1:0]          LAST_HALF = CB'(N - 1);
    localparam logic [CB-1:0]          LAST_COL  = CB'(2 * N - 1);
    localparam logic [CB-1:0]          RIGHT_OFS = CB'(N);
    localparam logic [RB:0]            ROWS      = (RB + 1)'(N);
    localparam logic signed [W-1:0]    ONE       = W'(1) << FRAC;
    localparam logic signed [2*W-1:0]  RECIP_NUM = (2 * W)'(1) << (2 * FRAC);

    typedef enum logic [2:0] {
        LOAD,
        PIVOT,
        NORM,
        FACT,
        ELIM,
        OUT
`ifdef MATINV_PIVOT_SWAP_EN
        , SRCH
`endif
    } state_t;

    state_t state, state_nxt;

    // Augmented matrix: columns 0..N-1 hold A, columns N..2N-1 hold the inverse being built.
    logic signed [W-1:0] m [N][2*N];

    // r/c are shared by LOAD, the elimination sweeps, and OUT. Only one of these is active at a time.
    logic [RB-1:0]       k;
    logic [RB-1:0]       r;
    logic [CB-1:0]       c;
    logic signed [W-1:0] recip;
    logic signed [W-1:0] f;

`ifdef MATINV_PIVOT_SWAP_EN
    logic [RB-1:0] s;
    logic          s_hit;
    logic          s_last;
`endif

    logic signed [W-1:0]   pivot;
    logic                  pivot_zero;
    logic                  col_last;
    logic                  half_end;
    logic [RB:0]           rn;
    logic                  rows_more;
    logic [RB-1:0]         first_row;
    logic signed [2*W-1:0] quot;
    logic signed [2*W-1:0] norm_prod;
    logic signed [2*W-1:0] elim_prod;
    logic signed [W-1:0]   norm_res;
    logic signed [W-1:0]   elim_res;

    always_comb begin
        pivot      = m[k][CB'(k)];
        pivot_zero = (pivot == '0);
        col_last   = (c == LAST_COL);
        half_end   = (r == LAST_ROW) && (c == LAST_HALF);

        // Next elimination row after r, stepping over the pivot row.
        rn = {1'b0, r} + (RB + 1)'(1);
        if (rn == {1'b0, k}) begin
            rn = rn + (RB + 1)'(1);
        end
        rows_more = (rn < ROWS);
        first_row = (k == '0) ? RB'(1) : '0;

        quot      = RECIP_NUM / $signed({{W{pivot[W-1]}}, pivot});
        // Products are formed at 2W bits. The low 2W bits of the sign-extended product are exact.
        norm_prod = $signed({{W{m[k][c][W-1]}}, m[k][c]}) * $signed({{W{recip[W-1]}}, recip});
        elim_prod = $signed({{W{f[W-1]}}, f}) * $signed({{W{m[k][c][W-1]}}, m[k][c]});
        norm_res  = W'(norm_prod >>> FRAC);
        elim_res  = m[r][c] - W'(elim_prod >>> FRAC);

`ifdef MATINV_PIVOT_SWAP_EN
        s_hit  = (m[s][CB'(k)] != '0);
        s_last = (s == LAST_ROW);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && half_end) begin
                    state_nxt = PIVOT;
                end
            end
            PIVOT: begin
                if (!pivot_zero) begin
                    state_nxt = NORM;
`ifdef MATINV_PIVOT_SWAP_EN
                end else if (k != LAST_ROW) begin
                    state_nxt = SRCH;
`endif
                end else begin
                    state_nxt = LOAD;
                end
            end
            NORM: begin
                if (col_last) begin
                    state_nxt = FACT;
                end
            end
            FACT: state_nxt = ELIM;
            ELIM: begin
                if (col_last) begin
                    if (rows_more) begin
                        state_nxt = FACT;
                    end else if (k == LAST_ROW) begin
                        state_nxt = OUT;
                    end else begin
                        state_nxt = PIVOT;
                    end
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = m[r][RIGHT_OFS + c];
                out_last  = half_end;
                if (out_ready && half_end) begin
                    state_nxt = LOAD;
                end
            end
`ifdef MATINV_PIVOT_SWAP_EN
            SRCH: begin
                if (s_hit) begin
                    state_nxt = PIVOT;
                end else if (s_last) begin
                    state_nxt = LOAD;
                end
            end
`endif
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k        <= '0;
            r        <= '0;
            c        <= '0;
            recip    <= '0;
            f        <= '0;
            done     <= 1'b0;
            singular <= 1'b0;
`ifdef MATINV_PIVOT_SWAP_EN
            s        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        m[r][c]             <= in_data;
                        m[r][RIGHT_OFS + c] <= (CB'(r) == c) ? ONE : '0;
                        if (c == LAST_HALF) begin
                            c <= '0;
                            if (r == LAST_ROW) begin
                                r <= '0;
                                k <= '0;
                            end else begin
                                r <= r + RB'(1);
                            end
                        end else begin
                            c <= c + CB'(1);
                        end
                    end
                end
                PIVOT: begin
                    if (!pivot_zero) begin
                        recip <= W'(quot);
                        c     <= '0;
`ifdef MATINV_PIVOT_SWAP_EN
                    end else if (k != LAST_ROW) begin
                        s <= k + RB'(1);
`endif
                    end else begin
                        singular <= 1'b1;
                        done     <= 1'b1;
                        k        <= '0;
                        r        <= '0;
                        c        <= '0;
                    end
                end
                NORM: begin
                    m[k][c] <= norm_res;
                    if (col_last) begin
                        c <= '0;
                        r <= first_row;
                    end else begin
                        c <= c + CB'(1);
                    end
                end
                FACT: f <= m[r][CB'(k)];
                ELIM: begin
                    m[r][c] <= elim_res;
                    if (col_last) begin
                        c <= '0;
                        if (rows_more) begin
                            r <= RB'(rn);
                        end else if (k == LAST_ROW) begin
                            k <= '0;
                            r <= '0;
                        end else begin
                            k <= k + RB'(1);
                        end
                    end else begin
                        c <= c + CB'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (c == LAST_HALF) begin
                            c <= '0;
                            if (r == LAST_ROW) begin
                                r        <= '0;
                                done     <= 1'b1;
                                singular <= 1'b0;
                            end else begin
                                r <= r + RB'(1);
                            end
                        end else begin
                            c <= c + CB'(1);
                        end
                    end
                end
`ifdef MATINV_PIVOT_SWAP_EN
                SRCH: begin
                    if (s_hit) begin
                        for (int cc = 0; cc < 2 * N; cc++) begin
                            m[k][cc] <= m[s][cc];
                            m[s][cc] <= m[k][cc];
                        end
                    end else if (s_last) begin
                        singular <= 1'b1;
                        done     <= 1'b1;
                        k        <= '0;
                        r        <= '0;
                        c        <= '0;
                    end else begin
                        s <= s + RB'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/matrix_inverse_seq.md
MATRIX_INVERSE_SEQ -- requirements
Module: matrix_inverse_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, legal range 2..8: matrix dimension.
REQ-002 The block SHALL have parameter W, default 16: element width, signed two's complement.
REQ-003 The block SHALL have parameter FRAC, default 8: fractional bits, Q(W-FRAC).FRAC; 0x0100 = 1.0 at defaults.
REQ-004 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  input element valid.
REQ-008 in_ready  out  1  block accepts an input element.
REQ-009 in_data  in  W  matrix A element, row-major order.
REQ-010 out_valid  out  1  inverse element valid.
REQ-011 out_ready  in  1  downstream accepts an output element.
REQ-012 out_data  out  W  inverse element, row-major order.
REQ-013 out_last  out  1  marks element N*N-1 of the output stream.
REQ-014 busy  out  1  high in every state except LOAD.
REQ-015 done  out  1  one-cycle pulse when a job ends.
REQ-016 singular  out  1  sticky error flag for the job that just ended.

Function
REQ-017 The FSM SHALL have the states LOAD, PIVOT, NORM, FACT, ELIM, OUT and, if compiled in, SRCH.
REQ-018 In LOAD, in_ready=1; each in_valid&&in_ready handshake SHALL store the next element; after the N*N-th handshake the FSM SHALL enter PIVOT for k=0, with the augmented right half initialised to identity.
REQ-019 PIVOT (1 cycle): pivot = A[k][k]; if the pivot is nonzero, the block SHALL latch recip = (1<<2*FRAC)/pivot, truncated toward zero, and enter NORM; a zero pivot SHALL be handled per REQ-031/032.
REQ-020 NORM SHALL update one element of the 2N-wide augmented row k per cycle: x = (x*recip)>>>FRAC, truncated to W.
REQ-021 For each row r!=k in ascending order, FACT SHALL latch f = A[r][k] (1 cycle); ELIM (2N cycles) SHALL then set x[r][c] = x[r][c] - ((f*x[k][c])>>>FRAC), truncated to W.
REQ-022 After the last row, k SHALL increment; after k=N-1 the FSM SHALL enter OUT.
REQ-023 Latency: first out_valid SHALL assert exactly N*N*(2N+1) cycles after the last input handshake when no zero pivot occurs (144 at N=4).
REQ-024 OUT SHALL stream the right half in row-major order; out_data/out_last SHALL be held stable while out_valid && !out_ready.
REQ-025 On the handshake carrying out_last=1, the block SHALL pulse done, clear singular, and return to LOAD.
REQ-026 in_ready SHALL be 0 in all states other than LOAD; in_valid in those states SHALL be ignored.
REQ-027 Products SHALL be formed at 2W bits before shifting; no saturation; overflow wraps.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL enter LOAD with element count 0, k=0.
REQ-029 Under reset, in_ready SHALL be 1 (from the cycle after reset deasserts); out_valid, out_data, out_last, busy, done and singular SHALL all be 0.
REQ-030 A reset in any state (mid-load, mid-compute, or mid-output) SHALL discard the job with no done pulse.

Configuration
REQ-031 With macro MATINV_PIVOT_SWAP_EN defined, a zero pivot SHALL enter SRCH, which tests rows k+1..N-1 one per cycle; the first row with a nonzero column-k element SHALL be swapped with row k in a single cycle, then return to PIVOT; if no such row exists, the job SHALL be handled as REQ-032.
REQ-032 Without the macro, or when no row qualifies, a zero pivot SHALL set singular=1, pulse done in the same cycle, emit no output, and return to LOAD; singular SHALL stay set until the next job's done or reset.

Verification
REQ-033 N=4, identity input (diagonal 0x0100) -> identity output, out_last on the 16th element, first out_valid 144 cycles after the last input.
REQ-034 N=4, diagonal 0x0200 (2.0) -> diagonal 0x0080 (0.5), off-diagonal 0x0000.
REQ-035 N=4, all-zero input -> singular=1 and done in the same cycle, at most 1 cycle after load without the macro; no out_valid.
REQ-036 N=2, [[0,1.0],[1.0,0]] -> with MATINV_PIVOT_SWAP_EN: output [[0,1.0],[1.0,0]]; without it: singular=1.
REQ-037 Identity job with out_ready toggled 1/0 each cycle -> 16 elements, each held stable while stalled, in order, one done pulse.
REQ-038 reset asserted for 1 cycle at compute cycle 50 -> in_ready=1 next cycle, no done; next identity job correct.
